pr_noc_hub: RTL and testbench

Request/response hub between the PageRank ant nodes. It accepts remote-page requests from each ant and queues them per port. It arbitrates round-robin, queries the ant that owns the page, and returns the owner's weighted contribution to the requester as a `{data,page_id}` response. The hub sits directly downstream of every ant's `request` output and directly upstream of every ant's `query` input and `response` input.

---
 rtl/pr_noc_hub_if.sv | 28 ++
 rtl/pr_noc_hub.sv | 153 +++++++++++++++
 tb/tb_pr_noc_hub.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pr_noc_hub_if.sv
// Bundled request/query/response signals between the PageRank ants and pr_noc_hub.
// master = ant side, slave = hub side.
`timescale 1ns/1ps
interface pr_noc_hub_if #(
    parameter int unsigned NODES  = 4,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned PAGE_W = 6
);
    logic [NODES-1:0]                  req_valid;
    logic [NODES*PAGE_W-1:0]           req_page;
    logic [NODES-1:0]                  req_ready;
    logic [NODES-1:0]                  query_valid;
    logic [NODES*PAGE_W-1:0]           query_page;
    logic [NODES*WIDTH-1:0]            reply;
    logic [NODES-1:0]                  response_valid;
    logic [NODES*(WIDTH+PAGE_W)-1:0]   response;
    logic                              busy;

    modport master (
        output req_valid, req_page, reply,
        input  req_ready, query_valid, query_page, response_valid, response, busy
    );

    modport slave (
        input  req_valid, req_page, reply,
        output req_ready, query_valid, query_page, response_valid, response, busy
    );
endinterface

// File: rtl/pr_noc_hub.sv
// Round-robin request/response hub between PageRank ants: per-port request FIFOs, owner query,
// response return. Optional duplicate-request suppression under `PR_HUB_DEDUP_EN.
`timescale 1ns/1ps
module pr_noc_hub #(
    parameter int unsigned NODES          = 4,
    parameter int unsigned PAGES_PER_NODE = 16,
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input logic         clk,
    input logic         reset,
    pr_noc_hub_if.slave bus
);
    localparam int unsigned PAGE_W = $clog2(NODES * PAGES_PER_NODE);
    localparam int unsigned PW     = $clog2(NODES);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned RESP_W = WIDTH + PAGE_W;

    typedef enum logic [1:0] {StIdle, StQuery, StDeliver} state_e;

    logic [PAGE_W-1:0] mem_q    [NODES][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q [NODES];
    logic [AW-1:0]     rd_ptr_q [NODES];
    logic [AW:0]       count_q  [NODES];

    logic [NODES-1:0] full, non_empty, push, store, pop;

    state_e                  state_q;
    logic [PW-1:0]           rr_q, cur_port_q;
    logic [PAGE_W-1:0]       cur_page_q;
    logic [NODES-1:0]        query_valid_q, response_valid_q;
    logic [NODES*PAGE_W-1:0] query_page_q;
    logic [NODES*RESP_W-1:0] response_q;

    logic              arb_fire, arb_found;
    logic [PW-1:0]     arb_base, arb_port, arb_idx, arb_owner, cur_owner;
    logic [PAGE_W-1:0] arb_page;
    logic [WIDTH-1:0]  owner_reply;
`ifdef PR_HUB_DEDUP_EN
    logic [AW-1:0]     last_idx;
`endif

    // Full is judged on the pre-pop count, so a pop never frees a slot in the same cycle.
    always_comb begin
        full      = '0;
        non_empty = '0;
        push      = '0;
        store     = '0;
        pop       = '0;
`ifdef PR_HUB_DEDUP_EN
        last_idx  = '0;
`endif
        for (int n = 0; n < NODES; n++) begin
            full[n]      = (count_q[n] == (AW+1)'(FIFO_DEPTH));
            non_empty[n] = (count_q[n] != '0);
            push[n]      = bus.req_valid[n] && !full[n];
`ifdef PR_HUB_DEDUP_EN
            last_idx = wr_ptr_q[n] - AW'(1);
            store[n] = push[n] && !(non_empty[n] &&
                       (mem_q[n][last_idx] == bus.req_page[n*PAGE_W +: PAGE_W]));
`else
            store[n] = push[n];
`endif
            pop[n] = arb_fire && (arb_port == PW'(n));
        end
    end

    // In DELIVER the priority already reflects the port being served now.
    always_comb begin
        arb_base  = (state_q == StDeliver) ? cur_port_q + PW'(1) : rr_q;
        arb_port  = arb_base;
        arb_idx   = arb_base;
        arb_found = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            arb_idx = arb_base + PW'(i);
            if (!arb_found && non_empty[arb_idx]) begin
                arb_port  = arb_idx;
                arb_found = 1'b1;
            end
        end
        arb_fire    = arb_found && (state_q != StQuery);
        arb_page    = mem_q[arb_port][rd_ptr_q[arb_port]];
        arb_owner   = arb_page[PAGE_W-1 -: PW];
        cur_owner   = cur_page_q[PAGE_W-1 -: PW];
        owner_reply = bus.reply[cur_owner*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < NODES; n++) begin
            if (store[n]) mem_q[n][wr_ptr_q[n]] <= bus.req_page[n*PAGE_W +: PAGE_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NODES; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                count_q[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < NODES; n++) begin
                if (store[n]) wr_ptr_q[n] <= wr_ptr_q[n] + AW'(1);
                if (pop[n])   rd_ptr_q[n] <= rd_ptr_q[n] + AW'(1);
                count_q[n] <= count_q[n] + (AW+1)'(store[n]) - (AW+1)'(pop[n]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            rr_q             <= '0;
            cur_port_q       <= '0;
            cur_page_q       <= '0;
            query_valid_q    <= '0;
            query_page_q     <= '0;
            response_valid_q <= '0;
            response_q       <= '0;
        end else begin
            query_valid_q    <= '0;
            response_valid_q <= '0;
            // arb_fire is only ever true in IDLE or DELIVER.
            if (arb_fire) begin
                cur_port_q                                <= arb_port;
                cur_page_q                                <= arb_page;
                query_valid_q[arb_owner]                  <= 1'b1;
                query_page_q[arb_owner*PAGE_W +: PAGE_W]  <= arb_page;
                state_q                                   <= StQuery;
            end
            unique case (state_q)
                StIdle: ;
                StQuery: begin
                    response_valid_q[cur_port_q]                <= 1'b1;
                    response_q[cur_port_q*RESP_W +: RESP_W]     <= {owner_reply, cur_page_q};
                    state_q                                     <= StDeliver;
                end
                StDeliver: begin
                    rr_q <= cur_port_q + PW'(1);
                    if (!arb_fire) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready      = ~full;
    assign bus.query_valid    = query_valid_q;
    assign bus.query_page     = query_page_q;
    assign bus.response_valid = response_valid_q;
    assign bus.response       = response_q;
    assign bus.busy           = (state_q != StIdle) || (|non_empty);
endmodule

// File: tb/tb_pr_noc_hub.sv
// Directed self-checking bench for pr_noc_hub: latency, round-robin, FIFO full, self-query,
// mid-transaction reset and duplicate handling.
`timescale 1ns/1ps
module tb_pr_noc_hub;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    logic [15:0] reply_val [4];
    logic [1:0]  rp_port [$];
    logic [21:0] rp_word [$];
    int          rp_cyc  [$];

    pr_noc_hub_if #(.NODES(4), .WIDTH(16), .PAGE_W(6)) bus ();

    pr_noc_hub dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Ant model: reply depends on the page it is asked about.
    always_comb begin
        for (int n = 0; n < 4; n++)
            bus.reply[16*n +: 16] = reply_val[n] + {10'b0, bus.query_page[6*n +: 6]};
    end

    always @(negedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (bus.response_valid[n]) begin
                rp_port.push_back(2'(n));
                rp_word.push_back(bus.response[22*n +: 22]);
                rp_cyc.push_back(cyc);
            end
        end
    end

    function automatic logic [21:0] exp_word(input logic [5:0] p);
        logic [15:0] d;
        d = reply_val[p[5:4]] + {10'b0, p};
        return {d, p};
    endfunction

    task automatic drive_cycle(input logic [3:0] v, input logic [23:0] pages);
        bus.req_valid = v;
        bus.req_page  = pages;
        @(posedge clk);
        #1;
        bus.req_valid = '0;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rp_port.delete();
        rp_word.delete();
        rp_cyc.delete();
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: hub still busy after %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (bus.req_ready !== 4'hF) begin
            fails++; $display("FAIL reset_ready: got %h expected f", bus.req_ready);
        end
        tests++;
        if (bus.query_valid !== 4'h0 || bus.response_valid !== 4'h0) begin
            fails++; $display("FAIL reset_valid: got q=%h r=%h expected 0", bus.query_valid,
                              bus.response_valid);
        end
        tests++;
        if (bus.busy !== 1'b0 || bus.query_page !== '0 || bus.response !== '0) begin
            fails++; $display("FAIL reset_data: got busy=%b qp=%h rsp=%h expected 0", bus.busy,
                              bus.query_page, bus.response);
        end
    endtask

    task automatic test_single();
        do_reset();
        reply_val[2] = 16'h1211;  // 0x1211 + page 0x23 = 0x1234
        drive_cycle(4'b0010, {6'h0, 6'h0, 6'h23, 6'h0});
        @(posedge clk); #1;
        tests++;
        if (bus.query_valid !== 4'b0100 || bus.query_page[17:12] !== 6'h23) begin
            fails++; $display("FAIL single_query: got qv=%b qp=%h expected 0100 23",
                              bus.query_valid, bus.query_page[17:12]);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.response_valid !== 4'b0010 || bus.response[43:22] !== {16'h1234, 6'h23}) begin
            fails++; $display("FAIL single_resp: got rv=%b rsp=%h expected 0010 %h",
                              bus.response_valid, bus.response[43:22], {16'h1234, 6'h23});
        end
        @(posedge clk); #1;
        tests++;
        if (bus.response_valid !== 4'b0 || bus.query_valid !== 4'b0 ||
            bus.response[43:22] !== {16'h1234, 6'h23} || bus.query_page[17:12] !== 6'h23) begin
            fails++; $display("FAIL single_hold: got rv=%b qv=%b rsp=%h qp=%h expected 0 0 %h 23",
                              bus.response_valid, bus.query_valid, bus.response[43:22],
                              {16'h1234, 6'h23}, bus.query_page[17:12]);
        end
    endtask

    task automatic test_round_robin();
        logic [5:0] pg [4];
        pg[0] = 6'h05; pg[1] = 6'h31; pg[2] = 6'h1A; pg[3] = 6'h2C;
        do_reset();
        drive_cycle(4'hF, {pg[3], pg[2], pg[1], pg[0]});
        wait_idle("rr_drain", 40);
        tests++;
        if (rp_port.size() != 4) begin
            fails++; $display("FAIL rr_count: got %0d expected 4", rp_port.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (rp_port[i] !== 2'(i) || rp_word[i] !== exp_word(pg[i])) begin
                    fails++; $display("FAIL rr_order[%0d]: got port %0d word %h expected %0d %h",
                                      i, rp_port[i], rp_word[i], i, exp_word(pg[i]));
                end
            end
            tests++;
            if (rp_cyc[1] - rp_cyc[0] != 2 || rp_cyc[3] - rp_cyc[2] != 2) begin
                fails++; $display("FAIL rr_spacing: got %0d,%0d expected 2,2",
                                  rp_cyc[1] - rp_cyc[0], rp_cyc[3] - rp_cyc[2]);
            end
        end
        rp_port.delete(); rp_word.delete(); rp_cyc.delete();
        drive_cycle(4'b1001, {6'h3C, 6'h0, 6'h0, 6'h12});
        wait_idle("rr_wrap_drain", 40);
        tests++;
        if (rp_port.size() != 2 || rp_port[0] !== 2'd0 || rp_port[1] !== 2'd3) begin
            fails++; $display("FAIL rr_wrap: got %0d responses first port %0d expected 2, 0",
                              rp_port.size(), rp_port.size() > 0 ? rp_port[0] : 2'd0);
        end
    endtask

    task automatic test_fifo_full();
        int n2 = 0;
        bit order_ok = 1'b1;
        do_reset();
        drive_cycle(4'b0111, {6'h0, 6'h20, 6'h02, 6'h01});
        drive_cycle(4'b0100, {6'h0, 6'h21, 12'h0});
        drive_cycle(4'b0100, {6'h0, 6'h22, 12'h0});
        tests++;
        if (bus.req_ready[2] !== 1'b1) begin
            fails++; $display("FAIL full_ready3: got %b expected 1", bus.req_ready[2]);
        end
        drive_cycle(4'b0100, {6'h0, 6'h23, 12'h0});
        tests++;
        if (bus.req_ready[2] !== 1'b0) begin
            fails++; $display("FAIL full_ready4: got %b expected 0", bus.req_ready[2]);
        end
        drive_cycle(4'b0100, {6'h0, 6'h24, 12'h0});
        tests++;
        if (bus.req_ready !== 4'b1011) begin
            fails++; $display("FAIL full_ready5: got %b expected 1011", bus.req_ready);
        end
        wait_idle("full_drain", 60);
        for (int i = 0; i < rp_port.size(); i++) begin
            if (rp_port[i] == 2'd2) begin
                if (rp_word[i][5:0] !== 6'(6'h20 + n2)) order_ok = 1'b0;
                n2++;
            end
        end
        tests++;
        if (n2 != 4 || !order_ok || rp_port.size() != 6) begin
            fails++; $display("FAIL full_resps: got %0d port2 (order ok %b) of %0d expected 4 of 6",
                              n2, order_ok, rp_port.size());
        end
    endtask

    task automatic test_self_query();
        do_reset();
        drive_cycle(4'b1000, {6'h3F, 18'h0});
        @(posedge clk); #1;
        tests++;
        if (bus.query_valid !== 4'b1000 || bus.query_page[23:18] !== 6'h3F) begin
            fails++; $display("FAIL self_query: got qv=%b qp=%h expected 1000 3f",
                              bus.query_valid, bus.query_page[23:18]);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.response_valid !== 4'b1000 || bus.response[87:66] !== exp_word(6'h3F)) begin
            fails++; $display("FAIL self_resp: got rv=%b rsp=%h expected 1000 %h",
                              bus.response_valid, bus.response[87:66], exp_word(6'h3F));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_cycle(4'b0010, {12'h0, 6'h05, 6'h0});
        @(posedge clk); #1;
        tests++;
        if (bus.query_valid !== 4'b0001) begin
            fails++; $display("FAIL mid_query: got %b expected 0001", bus.query_valid);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (bus.query_valid !== 4'b0 || bus.response_valid !== 4'b0 || bus.busy !== 1'b0 ||
            bus.req_ready !== 4'hF) begin
            fails++; $display("FAIL mid_async: got qv=%b rv=%b busy=%b rdy=%h expected 0 0 0 f",
                              bus.query_valid, bus.response_valid, bus.busy, bus.req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        rp_port.delete(); rp_word.delete(); rp_cyc.delete();
        repeat (6) @(posedge clk);
        #1;
        tests++;
        if (rp_port.size() != 0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL mid_no_resp: got %0d responses busy=%b expected 0 0",
                              rp_port.size(), bus.busy);
        end
    endtask

    task automatic test_dedup();
`ifdef PR_HUB_DEDUP_EN
        int exp_n = 2;
`else
        int exp_n = 3;
`endif
        do_reset();
        drive_cycle(4'b0001, {18'h0, 6'h11});
        drive_cycle(4'b0001, {18'h0, 6'h11});
        drive_cycle(4'b0001, {18'h0, 6'h12});
        wait_idle("dedup_drain", 40);
        tests++;
        if (rp_port.size() != exp_n) begin
            fails++; $display("FAIL dedup_count: got %0d expected %0d", rp_port.size(), exp_n);
        end else begin
            tests++;
            if (rp_word[0][5:0] !== 6'h11 || rp_word[exp_n-1][5:0] !== 6'h12 ||
                rp_word[exp_n-1] !== exp_word(6'h12)) begin
                fails++; $display("FAIL dedup_pages: got %h..%h expected 11..%h",
                                  rp_word[0][5:0], rp_word[exp_n-1], exp_word(6'h12));
            end
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_page  = '0;
        reply_val[0] = 16'h1000; reply_val[1] = 16'h2000;
        reply_val[2] = 16'h3000; reply_val[3] = 16'h4000;
        #12;
        test_reset();
        test_single();
        test_round_robin();
        test_fifo_full();
        test_self_query();
        test_reset_mid();
        test_dedup();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
